// File: rtl/dt_tick_pixel_scheduler.sv
// dt_tick_pixel_scheduler: buffers per-point tick intervals and replays them as a
// train of pixel strobes after each line-start pulse.
module dt_tick_pixel_scheduler #(
  parameter int POINTS_PER_LINE_P = 360,
  parameter int FIFO_DEPTH_P = 16,
  parameter int DT_W_P = 16
) (
  input  logic clk_i,
  input  logic nrst_i,
  input  logic dt_ticks_valid_i,
  input  logic [DT_W_P-1:0] dt_ticks_i,
  output logic dt_ticks_ready_o,
  input  logic line_start_i,
  output logic pixel_strobe_o,
  output logic [$clog2(POINTS_PER_LINE_P)-1:0] pixel_idx_o,
  output logic line_busy_o,
  output logic line_done_o,
  output logic underrun_o,
  output logic [$clog2(FIFO_DEPTH_P):0] fifo_level_o
);
  localparam int IW = $clog2(POINTS_PER_LINE_P);
  localparam int AW = $clog2(FIFO_DEPTH_P);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, COUNT = 2'd2, DONE = 2'd3;
  localparam logic [IW-1:0] LAST = IW'(POINTS_PER_LINE_P - 1);
  logic [DT_W_P-1:0] mem [FIFO_DEPTH_P];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [1:0] state;
  logic [DT_W_P-1:0] cnt, head, d_eff;
  logic [IW-1:0] idx, nidx;
  logic push, pop, empty, start, expire, want, last_load;
  assign fifo_level_o = wr_ptr - rd_ptr;
  assign dt_ticks_ready_o = !fifo_level_o[AW];
  assign empty = fifo_level_o == '0;
  assign push = dt_ticks_valid_i && dt_ticks_ready_o;
  assign head = mem[rd_ptr[AW-1:0]];
  assign d_eff = head == '0 ? DT_W_P'(1) : head;
  // cnt==0 in COUNT marks the cycle the strobe is visible; the next interval loads then
  always_comb begin
    start = state == IDLE && line_start_i && !line_done_o;
    expire = state == COUNT && cnt == '0;
    want = start || state == LOAD || expire;
    pop = want && !empty;
    nidx = start ? '0 : expire ? idx + IW'(1) : idx;
    last_load = d_eff == DT_W_P'(1) && nidx == LAST;
  end
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= dt_ticks_i;
  end
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      pixel_strobe_o <= 1'b0;
      pixel_idx_o <= '0;
      line_busy_o <= 1'b0;
      line_done_o <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      pixel_strobe_o <= 1'b0;
      line_done_o <= 1'b0;
      if (start) begin
        line_busy_o <= 1'b1;
        pixel_idx_o <= '0;
      end
      if (want) begin
        idx <= nidx;
        if (pop) begin
          cnt <= d_eff - DT_W_P'(1);
          state <= last_load ? DONE : COUNT;
          if (d_eff == DT_W_P'(1)) begin
            pixel_strobe_o <= 1'b1;
            pixel_idx_o <= nidx;
          end
        end else begin
          underrun_o <= 1'b1;
          state <= LOAD;
        end
      end else if (state == COUNT) begin
        cnt <= cnt - DT_W_P'(1);
        if (cnt == DT_W_P'(1)) begin
          pixel_strobe_o <= 1'b1;
          pixel_idx_o <= idx;
          if (idx == LAST) state <= DONE;
        end
      end else if (state == DONE) begin
        line_done_o <= 1'b1;
        line_busy_o <= 1'b0;
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_dt_tick_pixel_scheduler.sv
// tb_dt_tick_pixel_scheduler: directed vectors for a 4-point line instance and a
// full 360-point streaming instance sharing the same stimulus.
module tb_dt_tick_pixel_scheduler;
  logic clk = 1'b0, nrst = 1'b0, vld = 1'b0, st = 1'b0;
  logic [15:0] d = '0;
  logic rdy4, stb4, done4, busy4, und4;
  logic [1:0] idx4;
  logic [4:0] lvl4;
  logic rdy360, stb360, done360, busy360, und360;
  logic [8:0] idx360;
  logic [4:0] lvl360;
  int total = 0, bad = 0;

  dt_tick_pixel_scheduler #(.POINTS_PER_LINE_P(4)) u4 (
    .clk_i(clk), .nrst_i(nrst), .dt_ticks_valid_i(vld), .dt_ticks_i(d),
    .dt_ticks_ready_o(rdy4), .line_start_i(st), .pixel_strobe_o(stb4),
    .pixel_idx_o(idx4), .line_busy_o(busy4), .line_done_o(done4),
    .underrun_o(und4), .fifo_level_o(lvl4));

  dt_tick_pixel_scheduler u360 (
    .clk_i(clk), .nrst_i(nrst), .dt_ticks_valid_i(vld), .dt_ticks_i(d),
    .dt_ticks_ready_o(rdy360), .line_start_i(st), .pixel_strobe_o(stb360),
    .pixel_idx_o(idx360), .line_busy_o(busy360), .line_done_o(done360),
    .underrun_o(und360), .fifo_level_o(lvl360));

  always #5 clk = ~clk;

  typedef struct {
    logic vld;
    logic [15:0] d;
    logic st;
    logic [11:0] exp;
  } vec_t;
  vec_t tv[18];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // {ready, strobe, idx, done, busy, underrun, level}
  function automatic logic [11:0] v4();
    return {rdy4, stb4, idx4, done4, busy4, und4, lvl4};
  endfunction

  function automatic logic [11:0] ex(logic s, logic [1:0] i, logic dn, logic b, logic [4:0] l);
    return {1'b1, s, i, dn, b, 1'b0, l};
  endfunction

  function automatic vec_t mk(logic v, logic [15:0] dd, logic s, logic [11:0] e);
    vec_t r;
    r.vld = v;
    r.d = dd;
    r.st = s;
    r.exp = e;
    return r;
  endfunction

  task automatic rst();
    vld = 1'b0;
    st = 1'b0;
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic push_one(input logic [15:0] v);
    @(negedge clk);
    vld = 1'b1;
    d = v;
  endtask

  logic [4:0] seq4 [7];
  logic [3:0] seq5 [5];
  int acc, pushed, n, last, t0, cyc, dones;
  bit started;

  initial begin
    tv[0] = mk(1, 5, 0, ex(0, 0, 0, 0, 0));
    tv[1] = mk(1, 3, 0, ex(0, 0, 0, 0, 1));
    tv[2] = mk(1, 1, 0, ex(0, 0, 0, 0, 2));
    tv[3] = mk(1, 2, 0, ex(0, 0, 0, 0, 3));
    tv[4] = mk(0, 0, 1, ex(0, 0, 0, 0, 4));
    for (int i = 5; i < 9; i++) tv[i] = mk(0, 0, 0, ex(0, 0, 0, 1, 3));
    tv[9] = mk(0, 0, 0, ex(1, 0, 0, 1, 3));
    tv[10] = mk(0, 0, 0, ex(0, 0, 0, 1, 2));
    tv[11] = mk(0, 0, 0, ex(0, 0, 0, 1, 2));
    tv[12] = mk(0, 0, 0, ex(1, 1, 0, 1, 2));
    tv[13] = mk(0, 0, 0, ex(1, 2, 0, 1, 1));
    tv[14] = mk(0, 0, 0, ex(0, 2, 0, 1, 0));
    tv[15] = mk(0, 0, 0, ex(1, 3, 0, 1, 0));
    tv[16] = mk(0, 0, 0, ex(0, 3, 1, 0, 0));
    tv[17] = mk(0, 0, 0, ex(0, 3, 0, 0, 0));
    // {strobe, idx, done, busy} for T+1..T+7 of the D=0 line
    seq4 = '{5'b1_00_0_1, 5'b0_00_0_1, 5'b1_01_0_1, 5'b1_10_0_1, 5'b1_11_0_1, 5'b0_11_1_0, 5'b0_11_0_0};
    // {strobe, idx, done} for T+1..T+5 of the all-D=1 line
    seq5 = '{4'b1_00_0, 4'b1_01_0, 4'b1_10_0, 4'b1_11_0, 4'b0_11_1};

    // basic line from the table, starting straight out of reset
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", v4(), 12'b1_0_00_0_0_0_00000);
    chk("reset_ready360", {rdy360, lvl360}, 6'b1_00000);
    nrst = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      chk($sformatf("vec%0d", i), v4(), tv[i].exp);
      vld = tv[i].vld;
      d = tv[i].d;
      st = tv[i].st;
    end

    // FIFO full and held beat
    rst();
    acc = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      vld = 1'b1;
      d = 16'd20;
      if (rdy4) acc++;
    end
    @(negedge clk);
    chk("full_accepted", acc, 16);
    chk("full_level_ready", {rdy4, lvl4}, 6'b0_10000);
    st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    chk("pop_frees_slot", {rdy4, lvl4}, 6'b1_01111);
    @(negedge clk);
    chk("held_beat_taken", {rdy4, lvl4}, 6'b0_10000);
    vld = 1'b0;

    // underrun stall at line start
    rst();
    @(negedge clk);
    chk("und_before", und4, 0);
    st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    chk("und_set", {und4, busy4, lvl4}, 7'b1_1_00000);
    @(negedge clk);
    @(negedge clk);
    vld = 1'b1;
    d = 16'd4;
    @(negedge clk);
    vld = 1'b0;
    chk("und_level1", lvl4, 1);
    @(negedge clk);
    chk("und_popped", lvl4, 0);
    @(negedge clk);
    @(negedge clk);
    chk("und_no_early", stb4, 0);
    @(negedge clk);
    chk("und_strobe", {stb4, idx4, und4}, 4'b1_00_1);

    // D=0 first entry, ignored mid-line and done-cycle starts
    rst();
    @(negedge clk);
    chk("und_cleared", und4, 0);
    push_one(16'd0);
    push_one(16'd2);
    push_one(16'd1);
    push_one(16'd1);
    @(negedge clk);
    vld = 1'b0;
    st = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      st = (k == 1 || k == 5);
      chk($sformatf("d0_seq%0d", k), {stb4, idx4, done4, busy4}, seq4[k]);
    end
    @(negedge clk);
    st = 1'b0;
    chk("late_start_ignored", busy4, 0);

    // reset mid-line
    rst();
    for (int i = 0; i < 4; i++) push_one(16'd2);
    @(negedge clk);
    vld = 1'b0;
    st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    @(negedge clk);
    chk("pre_rst_s0", {stb4, idx4}, 3'b1_00);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_s1", {stb4, idx4}, 3'b1_01);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    chk("async_reset", v4(), 12'b1_0_00_0_0_0_00000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("in_reset_no_done", v4(), 12'b1_0_00_0_0_0_00000);
    end
    nrst = 1'b1;
    for (int i = 0; i < 4; i++) push_one(16'd1);
    @(negedge clk);
    vld = 1'b0;
    st = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      st = 1'b0;
      chk($sformatf("post_rst%0d", k), {stb4, idx4, done4}, seq5[k]);
    end

    // full 360-point line streamed concurrently
    rst();
    pushed = 0; n = 0; last = 0; t0 = 0; cyc = 0; dones = 0; started = 0;
    for (int i = 0; i < 1150; i++) begin
      @(negedge clk);
      cyc++;
      if (stb360) begin
        if (n == 0) chk("first_delay", cyc - t0, 3);
        else chk("gap", cyc - last, 3);
        chk("idx360", idx360, n);
        n++;
        last = cyc;
      end
      if (done360) dones++;
      st = 1'b0;
      if (!started && lvl360 != 0) begin
        st = 1'b1;
        started = 1;
        t0 = cyc;
      end
      vld = pushed < 360;
      d = 16'd3;
      if (vld && rdy360) pushed++;
    end
    chk("stream_strobes", n, 360);
    chk("stream_done_once", dones, 1);
    chk("stream_pushed", pushed, 360);
    chk("stream_no_underrun", {und360, busy360}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dt_tick_pixel_scheduler.md
Name: dt_tick_pixel_scheduler

Overview:
- Consumes the stream of per-point tick intervals (dt_Ticks) produced by the CORDIC manager and buffers them in a small FIFO.
- On each line-start pulse it replays the buffered intervals as a train of pixel strobes. Pixel k fires exactly D_k clock cycles after pixel k-1.
- Sits between the CORDIC timing stage and the laser/pixel driver. It turns the non-linear mirror-angle timing into per-pixel firing instants.

Parameters:
- POINTS_PER_LINE_P, 360, strobes per line; pixel_idx_o counts 0..POINTS_PER_LINE_P-1.
- FIFO_DEPTH_P, 16, interval FIFO entries; power of 2, >=2.
- DT_W_P, 16, interval width in clk_i ticks.

Ports:
- clk_i  in  1  clock.
- nrst_i  in  1  reset, asynchronous, active-low.
- dt_ticks_valid_i  in  1  interval valid (from dt_Ticks_valid_o).
- dt_ticks_i  in  DT_W_P  interval D in clk_i cycles (from dt_Ticks_o).
- dt_ticks_ready_o  out  1  FIFO not full; a push occurs when valid and ready are both high.
- line_start_i  in  1  single-cycle line-start pulse.
- pixel_strobe_o  out  1  one-cycle pixel fire pulse.
- pixel_idx_o  out  clog2(POINTS_PER_LINE_P)  index of the current or last strobed pixel.
- line_busy_o  out  1  high from accepted line_start_i until line_done_o.
- line_done_o  out  1  one-cycle pulse when the line completes.
- underrun_o  out  1  sticky; set when an interval was needed and the FIFO was empty.
- fifo_level_o  out  clog2(FIFO_DEPTH_P)+1  current FIFO occupancy.

Behaviour:
- Reset values: all outputs 0 except dt_ticks_ready_o=1. FIFO is emptied, FSM goes to IDLE, index=0, counter=0. Reset mid-line aborts the line immediately and does not produce line_done_o.
- FIFO: synchronous, with registered pointers and an extra wrap bit.
  - Push when valid && ready. ready = level < FIFO_DEPTH_P.
  - A pop is allowed only if level > 0 at the start of the cycle. Data pushed in cycle t is poppable from t+1.
  - A simultaneous push and pop leaves the level unchanged.
  - A push attempt while full is not accepted; ready is 0 and the upstream holds its data.
- Interval rule: D=0 is treated as 1. The counter is loaded with D_eff and decrements once per cycle. The strobe fires in the cycle the counter reaches 0 (registered output).
- FSM states are IDLE, LOAD, COUNT, DONE.
  - IDLE: wait for line_start_i. On line_start_i, set index=0 and line_busy_o=1, then do the LOAD action in the same cycle.
    - The LOAD action pops and loads the counter.
    - If the FIFO is empty, go to LOAD and set underrun_o.
    - Pixel 0 strobes D_0 cycles after the cycle line_start_i was sampled high.
  - LOAD (underrun stall): wait for level > 0, then pop, load, and go to COUNT. The interval is measured from the pop cycle.
  - COUNT: decrement the counter. On expiry, assert pixel_strobe_o with pixel_idx_o = current index.
    - If index = POINTS_PER_LINE_P-1, go to DONE.
    - Otherwise increment the index and pop/load the next interval in the same cycle. This keeps strobes back-to-back exact, and D=1 gives consecutive-cycle strobes.
    - If the FIFO is empty at that moment, set underrun_o and go to LOAD.
  - DONE: assert line_done_o for one cycle (the cycle after the last strobe), clear line_busy_o, and return to IDLE. Intervals left in the FIFO are retained for the next line.
- line_start_i while line_busy_o=1 is ignored; there is no restart or queueing.
- line_start_i in the same cycle as line_done_o is ignored; a new start is accepted from the following cycle.
- underrun_o is cleared only by reset.
- pixel_idx_o holds its value between strobes and holds the last index after DONE until the next line_start_i.

Test Plan:
- Preload 4 intervals {5,3,1,2} with POINTS_PER_LINE_P=4, then pulse line_start_i at cycle T. Required response:
  - strobes at T+5, T+8, T+9, T+11 with idx 0..3;
  - line_done_o at T+12;
  - underrun_o stays 0.
- Push FIFO_DEPTH_P+2 intervals with no line start. Required response:
  - ready drops after 16 accepted;
  - fifo_level_o=16;
  - the held beat is accepted after a pop frees a slot.
- Pulse line_start_i with the FIFO empty, then push D=4 at T+3. Required response:
  - underrun_o=1 from T+1;
  - pop at T+4;
  - strobe idx0 at T+8.
- Push interval D=0 as the first entry, then pulse line_start_i. Required response: strobe one cycle after start. Also pulse line_start_i again mid-line; it is ignored and the index sequence is unaffected.
- Assert nrst_i low mid-line after 2 strobes. Required response:
  - all outputs reset, level=0, no line_done_o;
  - after release, a normal line runs correctly from idx 0.
- Stream 360 intervals of D=3 concurrently with the line via valid/ready. Required response:
  - 360 strobes spaced exactly 3 cycles apart;
  - line_done_o once;
  - underrun_o=0.
